// File: rtl/bfis_query_host_pkg.sv
// Shared types and helpers for the best-first-search host block.
// Header word layout: [31:24] magic, [23:19] zero, [18] timeout, [17] overflow, [16] bad_k, [15:0] result count.
package bfis_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAUNCH,
    RUN,
    HDR,
    DRAIN,
    TRAIL
  } state_e;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  localparam int BAD_K    = 0;
  localparam int OVERFLOW = 1;
  localparam int TIMEOUT  = 2;

  function automatic logic [31:0] hdr_pack(input logic [2:0] status, input logic [15:0] count);
    return {HDR_MAGIC, 5'b0, status[TIMEOUT], status[OVERFLOW], status[BAD_K], count};
  endfunction

endpackage

// File: rtl/bfis_query_host_result_fifo.sv
// First-word-fall-through result buffer: data_o always shows the oldest entry while not empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/bfis_query_host.sv
// Host framing for the best-first-search engine: loads a query frame, launches the engine,
// buffers its top-k results and returns a header / results / latency response stream.
module bfis_query_host
  import bfis_host_pkg::*;
#(
  parameter int          DIM            = 4,
  parameter int          K_MAX          = 8,
  parameter logic [31:0] SYNC_WORD      = 32'hFFFF_FFFF,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [31:0]       data_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  output logic [31:0]       data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic [DIM*32-1:0] query_out,
  output logic [15:0]       k_out,
  output logic [31:0]       vertex_id_out,
  output logic              start_out,
  input  logic [31:0]       result_in,
  input  logic              result_valid_in,
  input  logic              done_in,
  output logic              busy_out
);

  localparam int                IDX_W   = $clog2(DIM + 2);
  localparam int                CNT_W   = $clog2(K_MAX) + 1;
  localparam logic [IDX_W-1:0]  IDX_K   = IDX_W'(DIM);
  localparam logic [IDX_W-1:0]  IDX_V   = IDX_W'(DIM + 1);
  localparam logic [15:0]       K_LIMIT = 16'(K_MAX);
  localparam logic [31:0]       TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       query_q [DIM];
  logic [15:0]       k_q;
  logic [31:0]       vertex_q;
  logic [2:0]        status_q;
  logic [31:0]       cyc_q;
  logic              start_q;
  logic              ready_q;
  logic              busy_q;

  logic              in_xfer;
  logic              out_xfer;
  logic              is_sync;
  logic              bad_k;
  logic              accept_res;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_clr;
  logic [31:0]       fifo_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign in_xfer    = data_in_valid && ready_q;
  assign out_xfer   = data_out_valid && data_out_ready;
  assign is_sync    = (data_in == SYNC_WORD);
  assign bad_k      = (k_q == 16'd0) || (k_q > K_LIMIT);
  assign accept_res = (state_q == RUN) && result_valid_in && (16'(fifo_count) < k_q) && !fifo_full;
  assign fifo_push  = accept_res;
  assign fifo_pop   = (state_q == DRAIN) && out_xfer;
  assign fifo_clr   = (state_q == TRAIL) && out_xfer;

  assign data_in_ready  = ready_q;
  assign busy_out       = busy_q;
  assign start_out      = start_q;
  assign k_out          = k_q;
  assign vertex_id_out  = vertex_q;
  assign data_out_valid = (state_q == HDR) || (state_q == DRAIN) || (state_q == TRAIL);

  for (genvar g = 0; g < DIM; g++) begin : g_query
    assign query_out[g*32 +: 32] = query_q[g];
  end

  result_fifo #(
    .WIDTH(32),
    .DEPTH(K_MAX)
  ) u_fifo (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .clr_i  (fifo_clr),
    .push_i (fifo_push),
    .data_i (result_in),
    .pop_i  (fifo_pop),
    .data_o (fifo_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (in_xfer && is_sync) state_d = LOAD;
      LOAD:   if (in_xfer && !is_sync && idx_q == IDX_V) state_d = bad_k ? HDR : LAUNCH;
      LAUNCH: state_d = RUN;
      RUN:    if (done_in || cyc_q == TO_LAST) state_d = HDR;
      HDR:    if (out_xfer) state_d = fifo_empty ? TRAIL : DRAIN;
      DRAIN:  if (out_xfer && fifo_count == CNT_W'(1)) state_d = TRAIL;
      TRAIL:  if (out_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A rejected k never ran the engine, so its latency reads as zero regardless of the counter.
  always_comb begin
    data_out = '0;
    case (state_q)
      HDR:     data_out = hdr_pack(status_q, 16'(fifo_count));
      DRAIN:   data_out = fifo_data;
      TRAIL:   data_out = status_q[BAD_K] ? 32'd0 : cyc_q;
      default: data_out = '0;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      k_q      <= '0;
      vertex_q <= '0;
      status_q <= '0;
      cyc_q    <= '0;
      start_q  <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < DIM; i++) query_q[i] <= '0;
    end else begin
      state_q <= state_d;
      start_q <= (state_d == LAUNCH);
      ready_q <= (state_d == IDLE) || (state_d == LOAD);
      busy_q  <= !((state_d == IDLE) || (state_d == LOAD));
      case (state_q)
        IDLE: if (in_xfer && is_sync) idx_q <= '0;
        LOAD: begin
          if (in_xfer) begin
            if (is_sync) begin
              idx_q <= '0;
            end else begin
              for (int i = 0; i < DIM; i++) begin
                if (idx_q == IDX_W'(i)) query_q[i] <= data_in;
              end
              if (idx_q == IDX_K) k_q <= data_in[15:0];
              if (idx_q == IDX_V) begin
                vertex_q <= data_in;
                if (bad_k) status_q[BAD_K] <= 1'b1;
              end
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        LAUNCH: cyc_q <= '0;
        RUN: begin
          if (cyc_q != 32'hFFFF_FFFF) cyc_q <= cyc_q + 32'd1;
          if (result_valid_in && !accept_res) status_q[OVERFLOW] <= 1'b1;
          if (!done_in && cyc_q == TO_LAST) status_q[TIMEOUT] <= 1'b1;
        end
        TRAIL: begin
          if (out_xfer) begin
            status_q <= '0;
            cyc_q    <= '0;
            idx_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bfis_query_host.sv
// Directed bench for bfis_query_host: table of frames with hand-computed responses plus
// resync/backpressure and asynchronous-reset sequences.
module tb_bfis_query_host;
  import bfis_host_pkg::*;

  localparam logic [31:0] SYNC = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_in;
  logic [31:0]  data_in;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [31:0]  data_out;
  logic         data_out_valid;
  logic         data_out_ready;
  logic [127:0] query_out;
  logic [15:0]  k_out;
  logic [31:0]  vertex_id_out;
  logic         start_out;
  logic [31:0]  result_in;
  logic         result_valid_in;
  logic         done_in;
  logic         busy_out;

  int errors = 0;
  int checks = 0;
  int startCount = 0;

  logic [31:0] expWords [12];
  int          expN;

  // q and res are packed, so concatenations list the highest index first.
  typedef struct packed {
    logic [3:0][31:0] q;
    logic [15:0]      k;
    logic [31:0]      vid;
    int               nres;
    logic [7:0][31:0] res;
    int               doneAt;
    bit               expStart;
    logic [31:0]      expHdr;
    int               expCnt;
    logic [31:0]      expTrail;
  } vec_t;

  vec_t vecs [6];

  bfis_query_host #(
    .DIM(4),
    .K_MAX(8),
    .SYNC_WORD(32'hFFFF_FFFF),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .query_out      (query_out),
    .k_out          (k_out),
    .vertex_id_out  (vertex_id_out),
    .start_out      (start_out),
    .result_in      (result_in),
    .result_valid_in(result_valid_in),
    .done_in        (done_in),
    .busy_out       (busy_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (start_out === 1'b1) startCount <= startCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w);
    bit sent = 0;
    data_in       = w;
    data_in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (data_in_ready) begin
        @(negedge clk);
        sent = 1;
        break;
      end
      @(negedge clk);
    end
    data_in_valid = 1'b0;
    if (!sent) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_word: got ready=0 expected ready=1 for word %h", w);
    end
  endtask

  task automatic clearEngine();
    result_valid_in = 1'b0;
    result_in       = '0;
    done_in         = 1'b0;
  endtask

  task automatic receiveResponse(input bit toggle, input string tag);
    int          got = 0;
    bit          rdy = 1'b1;
    bit          holding = 1'b0;
    logic [31:0] held = '0;
    for (int c = 0; c < 400 && got < expN; c++) begin
      @(negedge clk);
      rdy = toggle ? ~rdy : 1'b1;
      data_out_ready = rdy;
      if (data_out_valid) begin
        if (holding) checkOutput({tag, "_hold"}, data_out, held);
        if (rdy) begin
          checkOutput($sformatf("%s_w%0d", tag, got), data_out, expWords[got]);
          got++;
          holding = 1'b0;
        end else begin
          held    = data_out;
          holding = 1'b1;
        end
      end
    end
    checkOutput({tag, "_words"}, got, expN);
    @(negedge clk);
    data_out_ready = 1'b0;
    checkOutput({tag, "_idle_valid"}, {31'b0, data_out_valid}, 32'd0);
  endtask

  task automatic runVector(input vec_t v, input bit toggle, input bit prefix, input string tag);
    int s0 = startCount;
    bit found = 0;
    if (prefix) begin
      applyStimulus(32'd12);
      applyStimulus(32'd34);
      applyStimulus(SYNC);
      applyStimulus(32'd100);
      applyStimulus(32'd101);
    end
    applyStimulus(SYNC);
    for (int i = 0; i < 4; i++) applyStimulus(v.q[i]);
    applyStimulus({16'd0, v.k});
    applyStimulus(v.vid);
    if (v.expStart) begin
      for (int i = 0; i < 30; i++) begin
        if (start_out) begin
          found = 1;
          break;
        end
        @(negedge clk);
      end
      checkOutput({tag, "_start"}, {31'b0, found}, 32'd1);
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("%s_query%0d", tag, i), query_out[i*32 +: 32], v.q[i]);
      checkOutput({tag, "_k"}, {16'd0, k_out}, {16'd0, v.k});
      checkOutput({tag, "_vertex"}, vertex_id_out, v.vid);
      for (int j = 1; j <= 150; j++) begin
        @(negedge clk);
        if (data_out_valid) break;
        if (j == 1) begin
          checkOutput({tag, "_ready_run"}, {31'b0, data_in_ready}, 32'd0);
          checkOutput({tag, "_busy_run"}, {31'b0, busy_out}, 32'd1);
        end
        result_valid_in = (j <= v.nres);
        result_in       = (j <= v.nres) ? v.res[j-1] : 32'd0;
        done_in         = (v.doneAt == j);
      end
      clearEngine();
    end
    checkOutput({tag, "_hdr_reached"}, {31'b0, data_out_valid}, 32'd1);
    checkOutput({tag, "_busy_hdr"}, {31'b0, busy_out}, 32'd1);
    expWords[0] = v.expHdr;
    for (int i = 0; i < v.expCnt; i++) expWords[i+1] = v.res[i];
    expWords[v.expCnt+1] = v.expTrail;
    expN = v.expCnt + 2;
    receiveResponse(toggle, tag);
    checkOutput({tag, "_start_count"}, startCount - s0, v.expStart ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst_in         = 1'b1;
    data_in        = '0;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    clearEngine();

    vecs[0] = '{q: {32'd1, 32'd1, 32'd7, 32'd5}, k: 16'd4, vid: 32'd1, nres: 4,
                res: {32'd0, 32'd0, 32'd0, 32'd0, 32'd6, 32'd2, 32'd9, 32'd3}, doneAt: 20,
                expStart: 1'b1, expHdr: 32'hA500_0004, expCnt: 4, expTrail: 32'h0000_0014};
    vecs[1] = '{q: {32'd13, 32'd12, 32'd11, 32'd10}, k: 16'd2, vid: 32'd2, nres: 5,
                res: {32'd0, 32'd0, 32'd0, 32'd25, 32'd24, 32'd23, 32'd22, 32'd21}, doneAt: 10,
                expStart: 1'b1, expHdr: 32'hA502_0002, expCnt: 2, expTrail: 32'd10};
    vecs[2] = '{q: {32'd4, 32'd3, 32'd2, 32'd1}, k: 16'd0, vid: 32'd3, nres: 0,
                res: '0, doneAt: 0, expStart: 1'b0, expHdr: 32'hA501_0000, expCnt: 0, expTrail: 32'd0};
    vecs[3] = '{q: {32'd4, 32'd3, 32'd2, 32'd1}, k: 16'd9, vid: 32'd4, nres: 0,
                res: '0, doneAt: 0, expStart: 1'b0, expHdr: 32'hA501_0000, expCnt: 0, expTrail: 32'd0};
    vecs[4] = '{q: {32'd8, 32'd8, 32'd8, 32'd8}, k: 16'd4, vid: 32'd5, nres: 1,
                res: {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd77}, doneAt: 0,
                expStart: 1'b1, expHdr: 32'hA504_0001, expCnt: 1, expTrail: 32'd100};
    vecs[5] = '{q: {32'd40, 32'd30, 32'd20, 32'd10}, k: 16'd8, vid: 32'd6, nres: 8,
                res: {32'd58, 32'd57, 32'd56, 32'd55, 32'd54, 32'd53, 32'd52, 32'd51}, doneAt: 8,
                expStart: 1'b1, expHdr: 32'hA500_0008, expCnt: 8, expTrail: 32'd8};

    @(negedge clk);
    checkOutput("rst_ready", {31'b0, data_in_ready}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy_out}, 32'd0);
    checkOutput("rst_valid", {31'b0, data_out_valid}, 32'd0);
    checkOutput("rst_start", {31'b0, start_out}, 32'd0);
    checkOutput("rst_data_out", data_out, 32'd0);
    checkOutput("rst_k", {16'd0, k_out}, 32'd0);
    rst_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle_ready", {31'b0, data_in_ready}, 32'd1);

    for (int i = 0; i < 6; i++) runVector(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

    $display("[TB] resync with output backpressure");
    begin
      vec_t rv;
      rv = '{q: {32'd1, 32'd1, 32'd7, 32'd5}, k: 16'd2, vid: 32'd3, nres: 2,
             res: {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd41, 32'd40}, doneAt: 6,
             expStart: 1'b1, expHdr: 32'hA500_0002, expCnt: 2, expTrail: 32'd6};
      runVector(rv, 1'b1, 1'b1, "resync");
    end

    $display("[TB] async reset during RUN");
    applyStimulus(SYNC);
    for (int i = 0; i < 4; i++) applyStimulus(32'd1 + i);
    applyStimulus(32'd4);
    applyStimulus(32'd9);
    for (int i = 0; i < 30 && !start_out; i++) @(negedge clk);
    @(negedge clk);
    result_valid_in = 1'b1;
    result_in       = 32'd55;
    @(negedge clk);
    clearEngine();
    @(negedge clk);
    #2 rst_in = 1'b1;
    #1;
    checkOutput("rrun_busy", {31'b0, busy_out}, 32'd0);
    checkOutput("rrun_ready", {31'b0, data_in_ready}, 32'd0);
    checkOutput("rrun_k", {16'd0, k_out}, 32'd0);
    checkOutput("rrun_query0", query_out[31:0], 32'd0);
    checkOutput("rrun_vertex", vertex_id_out, 32'd0);
    @(negedge clk);
    rst_in = 1'b0;
    runVector(vecs[1], 1'b0, 1'b0, "after_rrun");

    $display("[TB] async reset during DRAIN");
    applyStimulus(SYNC);
    for (int i = 0; i < 4; i++) applyStimulus(32'd9 - i);
    applyStimulus(32'd4);
    applyStimulus(32'd5);
    for (int i = 0; i < 30 && !start_out; i++) @(negedge clk);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      result_valid_in = 1'b1;
      result_in       = 32'd10 + j;
      done_in         = (j == 4);
    end
    @(negedge clk);
    clearEngine();
    checkOutput("rdrain_hdr", data_out, 32'hA500_0004);
    data_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    data_out_ready = 1'b0;
    checkOutput("rdrain_word", data_out, 32'd12);
    #2 rst_in = 1'b1;
    #1;
    checkOutput("rdrain_valid", {31'b0, data_out_valid}, 32'd0);
    checkOutput("rdrain_data", data_out, 32'd0);
    checkOutput("rdrain_busy", {31'b0, busy_out}, 32'd0);
    @(negedge clk);
    rst_in = 1'b0;
    runVector(vecs[0], 1'b0, 1'b0, "after_rdrain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
